enemy_pool: RTL and testbench
=============================

# enemy_pool

Parametrised enemy-slot manager, successor to the single-speed enemy generator. Accepts spawn requests through a req/ack handshake, allocates the lowest free slot, and moves each enemy once per frame at its own speed. Per-slot hit points, destruction and escape events, and per-pixel sprite address lookup are provided on one VGA-domain clock. Sits between the spawn/random logic, the collision unit, and the pixel mixer/BRAM.

## Interface
- `N_SLOT`, 16: number of enemy slots (1..32)
- `IDX_W`, 4: slot index width, at least clog2(N_SLOT)
- `X_SIZE`, 64: sprite width in pixels
- `Y_SIZE`, 64: sprite height in pixels
- `H_DISP`, 640: visible width
- `V_DISP`, 480: visible height
- `POS_W`, 10: x and fixed-y register width
- `SPD_W`, 3: per-slot speed width, in pixels per frame
- `HP_W`, 3: hit-point width
- `ADDR_W`, 12: sprite BRAM address width, at least clog2(X_SIZE*Y_SIZE)

Ports:
- `clk_vga`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `en_i`  in  1  0 freezes movement and spawning; display lookup still runs
- `v_sync_i`  in  1  VGA vertical sync, low during sync
- `spawn_req_i`  in  1  spawn request, held until acked
- `spawn_x_i`  in  POS_W  spawn x position
- `spawn_spd_i`  in  SPD_W  speed, pixels/frame; 0 is treated as 1
- `spawn_hp_i`  in  HP_W  initial HP; 0 is treated as 1
- `spawn_ack_o`  out  1  one-cycle accept pulse
- `spawn_idx_o`  out  IDX_W  slot allocated, valid with ack
- `hit_i`  in  N_SLOT  per-slot one-cycle hit pulses
- `destroyed_o`  out  1  one-cycle pulse, one slot per pulse
- `destroyed_idx_o`  out  IDX_W  destroyed slot
- `escaped_o`  out  1  pulse when an enemy leaves the bottom edge
- `req_x_addr_i`  in  POS_W  pixel x being drawn
- `req_y_addr_i`  in  POS_W  pixel y being drawn
- `enemy_vali_o`  out  1  enemy pixel present
- `curr_enemy_idx_o`  out  IDX_W  owning slot
- `bram_addr_o`  out  ADDR_W  sprite texel address
- `active_cnt_o`  out  IDX_W+1  live slots
- `full_o`  out  1  no free slot

## Operation
- Per-slot state: live, x, fixed_y (real_y + Y_SIZE), spd, hp. Each slot also has display-locked copies `dlive` and `dy`.
- Frame tick: the first cycle with v_sync_i low after a cycle with it high, detected with a registered v_sync_i. On the tick with en_i=1, every live slot does fixed_y += spd.
  - If the new fixed_y >= V_DISP + Y_SIZE, the slot is freed and escaped_o pulses. Several escapes in one tick give a single pulse.
- Lock: every cycle v_sync_i is low, `dlive<=live` and `dy<=fixed_y`. Values settle at the post-move positions. While v_sync_i is high the locked copies hold, so the display never tears.
- Spawn: when spawn_req_i=1, en_i=1 and a free slot exists, take the lowest free index. Load x, fixed_y=0, spd and hp, set live, and pulse ack one cycle. Requesters must drop or renew req after ack.
  - When full, no ack; the request waits.
  - A new slot is not displayed until the next lock.
- Hit: with `ENEMY_POOL_HP_EN`, a hit on a live slot decrements hp. When hp reaches 0 the slot is freed and its pending-destroy bit is set. Hits on free slots are ignored.
- Destroy reporting: a pending bitmap is drained lowest-index first, one per cycle, onto destroyed_o/destroyed_idx_o. Bits are never lost.
- Simultaneous events in one cycle:
  - Hit beats move: a slot killed in a tick cycle does not escape.
  - A slot freed this cycle is not reallocated until the next cycle.
  - A hit on the slot being spawned this cycle is ignored.
- Pixel lookup: a slot covers the pixel when dlive, x <= req_x < x+X_SIZE, and dy <= req_y+Y_SIZE < dy+Y_SIZE. All arithmetic is POS_W+1 bits unsigned, no wrap. The lowest covering index wins.
- Texel address: bram_addr = (req_y+Y_SIZE-dy)*X_SIZE + (req_x-x). This gives correct partial display at the top edge.
- active_cnt_o and full_o are registered popcount and compare of live.

## Timing
- enemy_vali_o, curr_enemy_idx_o and bram_addr_o are registered, one cycle after the req address.
- spawn_ack_o comes 1 cycle after req sampled with a free slot. State is visible in active_cnt_o the cycle after ack.
- destroyed_o comes 1 cycle after the killing hit at the earliest, plus the queue position.
- Reset value of every output is 0. Reset clears all slot, locked and pending state and the v_sync history.
- Reset mid-frame: nothing is displayed until the next lock.

## Configuration
- `ENEMY_POOL_HP_EN` defined: per-slot hp registers, and spawn_hp_i is honoured.
- Not defined: no hp storage; any hit on a live slot destroys it immediately, and spawn_hp_i is ignored.

## Test plan
- Reset, then 3 spawns at x=100/200/300 with spd=2 -> acks idx 0,1,2 on consecutive grants; active_cnt_o=3.
- N_SLOT+1 spawn requests -> N_SLOT acks, full_o=1, last req unacked. Free slot 5 by hit -> ack with idx 5 next cycle.
- Slot at x=100, spd=4, locked dy=Y_SIZE (real y=0), pixel (100,0) -> vali=1, addr=0 one cycle later. Pixel (163,63) -> addr=4095; pixel (164,0) -> vali=0.
- spd=7 enemy, count frame ticks until fixed_y >= 544 -> freed on tick 78 with one escaped_o pulse. Same-tick hit instead -> destroyed_o, no escaped_o.
- HP_EN, hp=3: two hits -> no event; third hit -> destroyed_idx_o=idx. Hits on slots 2 and 7 in the same cycle -> pulses for 2 then 7 on consecutive cycles.
- Overlapping slots 1 and 4 on a pixel -> curr_enemy_idx_o=1. Change fixed_y mid-frame with v_sync_i high -> lookup output unchanged until the next lock.

Source files
------------

// File: rtl/enemy_pool.sv
// enemy_pool: parametrised enemy-slot manager on the VGA clock.
//   Spawn requests take the lowest free slot (req/ack handshake). Every frame
//   tick each live enemy moves down by its own speed. Hits free a slot (or
//   decrement its hp), and destroyed slots are reported one per cycle. A
//   per-pixel lookup returns the owning slot and the sprite texel address.
//
// Build option: define ENEMY_POOL_HP_EN to store per-slot hit points and
//   honour spawn_hp_i. Without it, any hit on a live slot destroys it.
//
// Ports:
//   clk_vga, rst            clock, synchronous active-high reset
//   en_i                    0 freezes movement and spawning
//   v_sync_i                VGA vertical sync (low during sync)
//   spawn_req_i/x/spd/hp    spawn request and its parameters
//   spawn_ack_o/idx_o       one-cycle accept pulse and allocated slot
//   hit_i                   per-slot hit pulses
//   destroyed_o/idx_o       one destroyed slot per pulse
//   escaped_o               pulse when enemies leave the bottom edge
//   req_x/y_addr_i          pixel being drawn
//   enemy_vali_o, curr_enemy_idx_o, bram_addr_o   registered lookup result
//   active_cnt_o, full_o    registered live-slot count and full flag
module enemy_pool #(
    parameter int N_SLOT = 16,
    parameter int IDX_W  = 4,
    parameter int X_SIZE = 64,
    parameter int Y_SIZE = 64,
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int POS_W  = 10,
    parameter int SPD_W  = 3,
    parameter int HP_W   = 3,
    parameter int ADDR_W = 12
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic              en_i,
    input  logic              v_sync_i,
    input  logic              spawn_req_i,
    input  logic [POS_W-1:0]  spawn_x_i,
    input  logic [SPD_W-1:0]  spawn_spd_i,
    input  logic [HP_W-1:0]   spawn_hp_i,
    output logic              spawn_ack_o,
    output logic [IDX_W-1:0]  spawn_idx_o,
    input  logic [N_SLOT-1:0] hit_i,
    output logic              destroyed_o,
    output logic [IDX_W-1:0]  destroyed_idx_o,
    output logic              escaped_o,
    input  logic [POS_W-1:0]  req_x_addr_i,
    input  logic [POS_W-1:0]  req_y_addr_i,
    output logic              enemy_vali_o,
    output logic [IDX_W-1:0]  curr_enemy_idx_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [IDX_W:0]    active_cnt_o,
    output logic              full_o
);

    localparam logic [POS_W:0] XS_W  = (POS_W+1)'(X_SIZE);
    localparam logic [POS_W:0] YS_W  = (POS_W+1)'(Y_SIZE);
    localparam logic [POS_W:0] Y_LIM = (POS_W+1)'(V_DISP + Y_SIZE);

    logic [N_SLOT-1:0] live, dlive, pend;
    logic [POS_W-1:0]  x_r  [N_SLOT];
    logic [POS_W-1:0]  fy_r [N_SLOT];
    logic [POS_W-1:0]  dy_r [N_SLOT];
    logic [SPD_W-1:0]  spd_r[N_SLOT];
`ifdef ENEMY_POOL_HP_EN
    logic [HP_W-1:0]   hp_r [N_SLOT];
`endif
    logic              vs_q;
    logic              move_en;
    logic              spawn_found, grant;
    logic [IDX_W-1:0]  spawn_sel;
    logic [N_SLOT-1:0] kill, esc, drain_src, drain_oh;
    logic [IDX_W-1:0]  drain_idx;
    logic [POS_W:0]    nfy [N_SLOT];
    logic [IDX_W:0]    cnt;
    logic              pix_hit;
    logic [IDX_W-1:0]  pix_idx;
    logic [ADDR_W-1:0] pix_addr;
    logic [POS_W:0]    rx, ry;
    logic              unused_cfg;

`ifdef ENEMY_POOL_HP_EN
    assign unused_cfg = (H_DISP > 0);
`else
    assign unused_cfg = (H_DISP > 0) ^ (^spawn_hp_i);
`endif

    // Frame tick: falling edge of v_sync_i seen against its registered copy.
    assign move_en = vs_q && !v_sync_i && en_i;

    // Allocation uses the registered live vector, so a slot freed this cycle
    // only becomes allocatable next cycle.
    always_comb begin
        spawn_found = 1'b0;
        spawn_sel   = '0;
        for (int i = N_SLOT - 1; i >= 0; i--) begin
            if (!live[i]) begin
                spawn_found = 1'b1;
                spawn_sel   = IDX_W'(i);
            end
        end
    end

    assign grant = spawn_req_i && en_i && spawn_found;

    // A slot being spawned is not live yet, so hits on it drop out here.
    // Killed slots are excluded from movement, so a hit beats an escape.
    always_comb begin
        kill = '0;
        esc  = '0;
        for (int i = 0; i < N_SLOT; i++) begin
`ifdef ENEMY_POOL_HP_EN
            kill[i] = hit_i[i] && live[i] && (hp_r[i] <= HP_W'(1));
`else
            kill[i] = hit_i[i] && live[i];
`endif
            nfy[i] = {1'b0, fy_r[i]} + (POS_W+1)'(spd_r[i]);
            esc[i] = move_en && live[i] && !kill[i] && (nfy[i] >= Y_LIM);
        end
    end

    // Kills feed the drain directly so the earliest report is one cycle later.
    always_comb begin
        drain_src = pend | kill;
        drain_oh  = '0;
        drain_idx = '0;
        for (int i = N_SLOT - 1; i >= 0; i--) begin
            if (drain_src[i]) begin
                drain_oh  = N_SLOT'(1) << i;
                drain_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_SLOT; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, live[i]};
        end
    end

    // Vertical test works in fixed_y space (req_y + Y_SIZE) so sprites that
    // are partly above the screen still match with no negative arithmetic.
    always_comb begin
        pix_hit  = 1'b0;
        pix_idx  = '0;
        pix_addr = '0;
        rx = {1'b0, req_x_addr_i};
        ry = {1'b0, req_y_addr_i} + YS_W;
        for (int i = N_SLOT - 1; i >= 0; i--) begin
            if (dlive[i] && ({1'b0, x_r[i]} <= rx) && (rx < {1'b0, x_r[i]} + XS_W)
                && ({1'b0, dy_r[i]} <= ry) && (ry < {1'b0, dy_r[i]} + YS_W)) begin
                pix_hit  = 1'b1;
                pix_idx  = IDX_W'(i);
                pix_addr = ADDR_W'(32'(ry - {1'b0, dy_r[i]}) * 32'(X_SIZE)
                                   + 32'(rx - {1'b0, x_r[i]}));
            end
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            live <= '0; dlive <= '0; pend <= '0; vs_q <= 1'b0;
            for (int i = 0; i < N_SLOT; i++) begin
                x_r[i] <= '0; fy_r[i] <= '0; dy_r[i] <= '0; spd_r[i] <= '0;
`ifdef ENEMY_POOL_HP_EN
                hp_r[i] <= '0;
`endif
            end
            spawn_ack_o <= 1'b0; spawn_idx_o <= '0;
            destroyed_o <= 1'b0; destroyed_idx_o <= '0; escaped_o <= 1'b0;
            enemy_vali_o <= 1'b0; curr_enemy_idx_o <= '0; bram_addr_o <= '0;
            active_cnt_o <= '0; full_o <= 1'b0;
        end else begin
            vs_q <= v_sync_i;
            for (int i = 0; i < N_SLOT; i++) begin
                if (kill[i] || esc[i]) begin
                    live[i] <= 1'b0;
                end else if (live[i] && move_en) begin
                    fy_r[i] <= nfy[i][POS_W-1:0];
                end
`ifdef ENEMY_POOL_HP_EN
                if (hit_i[i] && live[i] && !kill[i]) begin
                    hp_r[i] <= hp_r[i] - HP_W'(1);
                end
`endif
                if (grant && (spawn_sel == IDX_W'(i))) begin
                    live[i]  <= 1'b1;
                    x_r[i]   <= spawn_x_i;
                    fy_r[i]  <= '0;
                    spd_r[i] <= (spawn_spd_i == '0) ? SPD_W'(1) : spawn_spd_i;
`ifdef ENEMY_POOL_HP_EN
                    hp_r[i]  <= (spawn_hp_i == '0) ? HP_W'(1) : spawn_hp_i;
`endif
                end
            end
            // Display copies only follow while v_sync_i is low, so nothing
            // tears during the visible part of the frame.
            if (!v_sync_i) begin
                dlive <= live;
                for (int i = 0; i < N_SLOT; i++) begin
                    dy_r[i] <= fy_r[i];
                end
            end
            spawn_ack_o <= grant;
            if (grant) spawn_idx_o <= spawn_sel;
            pend        <= drain_src & ~drain_oh;
            destroyed_o <= |drain_src;
            if (|drain_src) destroyed_idx_o <= drain_idx;
            escaped_o        <= |esc;
            enemy_vali_o     <= pix_hit;
            curr_enemy_idx_o <= pix_idx;
            bram_addr_o      <= pix_addr;
            active_cnt_o     <= cnt;
            full_o           <= &live;
        end
    end

endmodule

// File: tb/tb_enemy_pool.sv
// tb_enemy_pool: scoreboard bench for enemy_pool. Stimulus pushes expected
// acks, destroys, escapes and pixel results into queues; a negedge monitor
// pops and compares whenever the DUT presents the matching output.
module tb_enemy_pool;

    localparam int N_SLOT = 16;
    localparam int IDX_W  = 4;
    localparam int POS_W  = 10;
    localparam int SPD_W  = 3;
    localparam int HP_W   = 3;
    localparam int ADDR_W = 12;
`ifdef ENEMY_POOL_HP_EN
    localparam int HITS = 3;
`else
    localparam int HITS = 1;
`endif

    logic              clk_vga = 1'b0;
    logic              rst, en_i, v_sync_i, spawn_req_i;
    logic [POS_W-1:0]  spawn_x_i;
    logic [SPD_W-1:0]  spawn_spd_i;
    logic [HP_W-1:0]   spawn_hp_i;
    logic              spawn_ack_o;
    logic [IDX_W-1:0]  spawn_idx_o;
    logic [N_SLOT-1:0] hit_i;
    logic              destroyed_o;
    logic [IDX_W-1:0]  destroyed_idx_o;
    logic              escaped_o;
    logic [POS_W-1:0]  req_x_addr_i, req_y_addr_i;
    logic              enemy_vali_o;
    logic [IDX_W-1:0]  curr_enemy_idx_o;
    logic [ADDR_W-1:0] bram_addr_o;
    logic [IDX_W:0]    active_cnt_o;
    logic              full_o;

    enemy_pool dut (
        .clk_vga(clk_vga), .rst(rst), .en_i(en_i), .v_sync_i(v_sync_i),
        .spawn_req_i(spawn_req_i), .spawn_x_i(spawn_x_i), .spawn_spd_i(spawn_spd_i),
        .spawn_hp_i(spawn_hp_i), .spawn_ack_o(spawn_ack_o), .spawn_idx_o(spawn_idx_o),
        .hit_i(hit_i), .destroyed_o(destroyed_o), .destroyed_idx_o(destroyed_idx_o),
        .escaped_o(escaped_o), .req_x_addr_i(req_x_addr_i), .req_y_addr_i(req_y_addr_i),
        .enemy_vali_o(enemy_vali_o), .curr_enemy_idx_o(curr_enemy_idx_o),
        .bram_addr_o(bram_addr_o), .active_cnt_o(active_cnt_o), .full_o(full_o)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        int vali;
        int idx;
        int addr;
    } pix_t;

    int   ack_q[$];
    int   dest_q[$];
    int   esc_q[$];
    pix_t pix_q[$];
    int   checks = 0;
    int   fails = 0;
    int   tick_cnt = 0;
    logic pix_strobe = 1'b0;
    logic pix_due = 1'b0;
    int   mon_e;
    pix_t mon_p;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reportUnexpected(input string name, input int act);
        checks++;
        fails++;
        $display("[TB] FAIL %s: unexpected pulse with idx %0d, expected none", name, act);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_vga);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic req, input int x, input int spd, input int hp);
        spawn_req_i = req;
        spawn_x_i   = POS_W'(x);
        spawn_spd_i = SPD_W'(spd);
        spawn_hp_i  = HP_W'(hp);
    endtask

    task automatic doReset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // One frame: a high cycle, then two low cycles (tick, then settle lock).
    task automatic frame(input logic [N_SLOT-1:0] hv);
        v_sync_i = 1'b1;
        step(1);
        v_sync_i = 1'b0;
        hit_i    = hv;
        tick_cnt++;
        step(1);
        hit_i = '0;
        step(1);
        v_sync_i = 1'b1;
    endtask

    task automatic pixel(input int px, input int py, input int v, input int idx, input int addr);
        pix_t p;
        p.vali = v;
        p.idx  = idx;
        p.addr = addr;
        pix_q.push_back(p);
        req_x_addr_i = POS_W'(px);
        req_y_addr_i = POS_W'(py);
        pix_strobe   = 1'b1;
        step(1);
        pix_strobe = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((ack_q.size() + dest_q.size() + esc_q.size() + pix_q.size() > 0) && n < budget) begin
            step(1);
            n++;
        end
        if (ack_q.size() + dest_q.size() + esc_q.size() + pix_q.size() > 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain_timeout: %0d events outstanding, expected 0",
                     ack_q.size() + dest_q.size() + esc_q.size() + pix_q.size());
        end
    endtask

    // Monitor: compares each DUT event against the head of its queue.
    always @(negedge clk_vga) begin
        if (spawn_ack_o) begin
            if (ack_q.size() == 0) reportUnexpected("spawn_ack", int'(spawn_idx_o));
            else begin
                mon_e = ack_q.pop_front();
                checkOutput("spawn_idx", int'(spawn_idx_o), mon_e);
            end
        end
        if (destroyed_o) begin
            if (dest_q.size() == 0) reportUnexpected("destroyed", int'(destroyed_idx_o));
            else begin
                mon_e = dest_q.pop_front();
                checkOutput("destroyed_idx", int'(destroyed_idx_o), mon_e);
            end
        end
        if (escaped_o) begin
            if (esc_q.size() == 0) reportUnexpected("escaped", tick_cnt);
            else begin
                mon_e = esc_q.pop_front();
                checkOutput("escape_tick", tick_cnt, mon_e);
            end
        end
        if (pix_due && pix_q.size() > 0) begin
            mon_p = pix_q.pop_front();
            checkOutput("pix_vali", int'(enemy_vali_o), mon_p.vali);
            if (mon_p.vali != 0) begin
                checkOutput("pix_idx", int'(curr_enemy_idx_o), mon_p.idx);
                checkOutput("pix_addr", int'(bram_addr_o), mon_p.addr);
            end
        end
        pix_due = pix_strobe;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; en_i = 1'b1; v_sync_i = 1'b1; hit_i = '0;
        req_x_addr_i = '0; req_y_addr_i = '0;
        applyStimulus(1'b0, 0, 0, 0);
        step(2);
        @(negedge clk_vga);
        checkOutput("rst_ack", int'(spawn_ack_o), 0);
        checkOutput("rst_destroyed", int'(destroyed_o), 0);
        checkOutput("rst_escaped", int'(escaped_o), 0);
        checkOutput("rst_vali", int'(enemy_vali_o), 0);
        checkOutput("rst_addr", int'(bram_addr_o), 0);
        checkOutput("rst_cnt", int'(active_cnt_o), 0);
        checkOutput("rst_full", int'(full_o), 0);
        @(posedge clk_vga);
        #1 rst = 1'b0;

        // Three spawns on consecutive cycles, then fill the pool.
        $display("[TB] spawn and fill");
        for (int k = 0; k < 3; k++) begin
            ack_q.push_back(k);
            applyStimulus(1'b1, 100 * (k + 1), 2, 1);
            step(1);
        end
        applyStimulus(1'b0, 0, 2, 1);
        step(2);
        checkOutput("cnt_after_3", int'(active_cnt_o), 3);
        checkOutput("full_after_3", int'(full_o), 0);
        for (int k = 3; k < N_SLOT; k++) begin
            ack_q.push_back(k);
            applyStimulus(1'b1, 20 * k, 2, 1);
            step(1);
        end
        step(3);
        checkOutput("cnt_full", int'(active_cnt_o), N_SLOT);
        checkOutput("full_flag", int'(full_o), 1);
        // Request still pending; freeing slot 5 lets it through next cycle.
        hit_i = N_SLOT'(1) << 5;
        dest_q.push_back(5);
        ack_q.push_back(5);
        step(1);
        hit_i = '0;
        step(3);
        applyStimulus(1'b0, 0, 2, 1);
        step(2);
        checkOutput("cnt_refill", int'(active_cnt_o), N_SLOT);
        checkOutput("full_refill", int'(full_o), 1);
        waitDrain(20);

        // Lookup: 16 frames put speed-4 sprites at fixed_y 64 (real y 0).
        $display("[TB] pixel lookup");
        doReset();
        ack_q.push_back(0); applyStimulus(1'b1, 100, 4, 1); step(1);
        ack_q.push_back(1); applyStimulus(1'b1, 400, 4, 1); step(1);
        ack_q.push_back(2); applyStimulus(1'b1, 500, 4, 1); step(1);
        ack_q.push_back(3); applyStimulus(1'b1, 0,   0, 1); step(1);
        ack_q.push_back(4); applyStimulus(1'b1, 410, 4, 1); step(1);
        applyStimulus(1'b0, 0, 0, 1);
        step(1);
        pixel(100, 0, 0, 0, 0);
        for (int f = 0; f < 16; f++) frame('0);
        step(1);
        pixel(100, 0, 1, 0, 0);
        pixel(163, 63, 1, 0, 4095);
        pixel(164, 0, 0, 0, 0);
        pixel(99, 0, 0, 0, 0);
        pixel(420, 10, 1, 1, 660);
        pixel(5, 3, 1, 3, 3269);
        pixel(5, 16, 0, 0, 0);
        // Kill slot 1 during the visible frame; display must not change yet.
        hit_i = N_SLOT'(1) << 1;
        dest_q.push_back(1);
        step(1);
        hit_i = '0;
        step(2);
        pixel(420, 10, 1, 1, 660);
        frame('0);
        step(1);
        pixel(420, 10, 1, 4, 394);
        waitDrain(20);

        // Escape: two speed-7 enemies leave together on tick 78.
        $display("[TB] escape");
        doReset();
        tick_cnt = 0;
        ack_q.push_back(0); applyStimulus(1'b1, 0, 7, 1); step(1);
        ack_q.push_back(1); applyStimulus(1'b1, 80, 7, 1); step(1);
        applyStimulus(1'b0, 0, 7, 1);
        for (int t = 1; t <= 78; t++) begin
            if (t == 78) esc_q.push_back(78);
            frame('0);
        end
        step(3);
        checkOutput("cnt_after_escape", int'(active_cnt_o), 0);
        waitDrain(20);
        tick_cnt = 0;
        ack_q.push_back(0); applyStimulus(1'b1, 0, 7, 1); step(1);
        applyStimulus(1'b0, 0, 7, 1);
        for (int t = 1; t <= 77; t++) frame('0);
        dest_q.push_back(0);
        frame(N_SLOT'(1));
        step(3);
        checkOutput("cnt_after_kill", int'(active_cnt_o), 0);
        waitDrain(20);

        // Hits: free-slot hit ignored, hp countdown, two kills drain in order.
        $display("[TB] hits");
        doReset();
        for (int k = 0; k < 8; k++) begin
            ack_q.push_back(k);
            applyStimulus(1'b1, 60 * k, 1, 3);
            step(1);
        end
        applyStimulus(1'b0, 0, 1, 3);
        step(1);
        hit_i = N_SLOT'(1) << 12;
        step(1);
        hit_i = '0;
        step(2);
        for (int h = 1; h <= HITS; h++) begin
            if (h == HITS) dest_q.push_back(0);
            hit_i = N_SLOT'(1);
            step(1);
            hit_i = '0;
            step(2);
        end
        for (int h = 1; h <= HITS; h++) begin
            if (h == HITS) begin
                dest_q.push_back(2);
                dest_q.push_back(7);
            end
            hit_i = (N_SLOT'(1) << 2) | (N_SLOT'(1) << 7);
            step(1);
            hit_i = '0;
            step(2);
        end
        step(2);
        checkOutput("cnt_after_hits", int'(active_cnt_o), 5);
        waitDrain(20);

        checkOutput("ack_q_left", ack_q.size(), 0);
        checkOutput("dest_q_left", dest_q.size(), 0);
        checkOutput("esc_q_left", esc_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
